// File: rtl/mem_resp_pkg.sv
// Shared types for the main-memory responder and its initiators: FSM states and request direction.
// No logic lives here; idx_width() sizes index/counter fields that must be at least one bit wide.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        RD_BURST = 2'd2,
        WR_ACK   = 2'd3
    } resp_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage for the memory responder: synchronous write, combinational read, contents not reset.
// Latency: write lands at the clock edge, read data follows raddr in the same cycle.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 768,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory end of the cache miss/write-through path: one request at a time, fixed LATENCY to first beat,
// LINE_WORDS-beat refill on read, single-beat ack on write; no back-pressure on responses.
// Optional MEM_RESP_ERR_EN adds rsp_err and flags out-of-range accesses instead of wrapping mod DEPTH.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 768,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    input  logic                               req_rw,
    input  logic [ADDR_W-1:0]                  req_addr,
    input  logic [DATA_W-1:0]                  req_wdata,
    output logic                               req_ready,
    output logic                               rsp_valid,
    output logic [DATA_W-1:0]                  rsp_rdata,
    output logic [idx_width(LINE_WORDS)-1:0]   rsp_beat,
    output logic                               rsp_last
`ifdef MEM_RESP_ERR_EN
    ,
    output logic                               rsp_err
`endif
);

    localparam int BEAT_W = idx_width(LINE_WORDS);
    localparam int IDX_W  = idx_width(DEPTH);
    localparam int LAT_W  = idx_width(LATENCY);
    localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    // Out-of-range addresses fold back into the implemented words.
    function automatic logic [IDX_W-1:0] phys(input logic [ADDR_W-1:0] a);
        return IDX_W'(32'(a) % DEPTH_U);
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH_U;
    endfunction

    resp_state_t         state, state_nxt;
    logic [LAT_W-1:0]    lat_cnt, lat_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                accept;
    logic                beat_go;
    logic                ack_go;

    logic [ADDR_W-1:0]   beat_addr;
    logic [DATA_W-1:0]   arr_rdata;
    logic [DATA_W-1:0]   beat_data;
    logic                wr_en;

    logic                valid_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic [BEAT_W-1:0]   beat_out_nxt;
    logic                last_nxt;
    logic                err_nxt;
    logic                beat_err;
    logic                wr_err_q;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign beat_addr = addr_q + ADDR_W'(beat_cnt);

`ifdef MEM_RESP_ERR_EN
    assign wr_en     = accept && (req_rw == RW_WRITE) && in_range(req_addr);
    assign beat_err  = !in_range(beat_addr);
    assign beat_data = beat_err ? '0 : arr_rdata;
`else
    assign wr_en     = accept && (req_rw == RW_WRITE);
    assign beat_err  = 1'b0;
    assign beat_data = arr_rdata;
`endif

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .waddr  (phys(req_addr)),
        .wdata  (req_wdata),
        .raddr  (phys(beat_addr)),
        .rdata  (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lat_nxt      = lat_cnt;
        beat_nxt     = beat_cnt;
        beat_go      = 1'b0;
        ack_go       = 1'b0;
        valid_nxt    = 1'b0;
        rdata_nxt    = '0;
        beat_out_nxt = '0;
        last_nxt     = 1'b0;
        err_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = WAIT;
                    lat_nxt   = LAT_W'(LATENCY - 1);
                    beat_nxt  = '0;
                end
            end
            WAIT: begin
                // Leaving at count zero registers the first beat exactly LATENCY edges after accept.
                if (lat_cnt == '0) begin
                    if (rw_q == RW_WRITE) begin
                        state_nxt = WR_ACK;
                        ack_go    = 1'b1;
                    end else begin
                        state_nxt = RD_BURST;
                        beat_go   = 1'b1;
                    end
                end else begin
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end
            RD_BURST: begin
                if (rsp_last) begin
                    state_nxt = IDLE;
                end else begin
                    beat_go = 1'b1;
                end
            end
            WR_ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (beat_go) begin
            beat_nxt     = beat_cnt + BEAT_W'(1);
            valid_nxt    = 1'b1;
            rdata_nxt    = beat_data;
            beat_out_nxt = beat_cnt;
            last_nxt     = (beat_cnt == LAST_BEAT);
            err_nxt      = beat_err;
        end else if (ack_go) begin
            valid_nxt    = 1'b1;
            last_nxt     = 1'b1;
            err_nxt      = wr_err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt   <= '0;
            beat_cnt  <= '0;
            rw_q      <= RW_READ;
            addr_q    <= '0;
            wr_err_q  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_beat  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            lat_cnt   <= lat_nxt;
            beat_cnt  <= beat_nxt;
            if (accept) begin
                rw_q     <= req_rw;
                addr_q   <= req_addr & ~LINE_MASK;
                wr_err_q <= !in_range(req_addr);
            end
            rsp_valid <= valid_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_beat  <= beat_out_nxt;
            rsp_last  <= last_nxt;
        end
    end

`ifdef MEM_RESP_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= err_nxt;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_nxt ^ wr_err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default parameters; build with MEM_RESP_ERR_EN to cover rsp_err.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_rw;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_beat;
    logic        rsp_last;
`ifdef MEM_RESP_ERR_EN
    logic        rsp_err;
`endif

    int vectors;
    int miscompares;

    logic        s_valid [16];
    logic [31:0] s_data  [16];
    logic [1:0]  s_beat  [16];
    logic        s_last  [16];
    logic        s_ready [16];
    logic        s_err   [16];

    mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_beat  (rsp_beat),
        .rsp_last  (rsp_last)
`ifdef MEM_RESP_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic capture(input int c);
        s_valid[c] = rsp_valid;
        s_data[c]  = rsp_rdata;
        s_beat[c]  = rsp_beat;
        s_last[c]  = rsp_last;
        s_ready[c] = req_ready;
`ifdef MEM_RESP_ERR_EN
        s_err[c]   = rsp_err;
`else
        s_err[c]   = 1'b0;
`endif
    endtask

    // Cycle 0 is the cycle right after the accepting edge; samples are taken at the falling edge.
    task automatic run_req(input logic rw, input logic [9:0] addr, input logic [31:0] data, input int ncyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_wait got=%b want=1", req_ready);
        end
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            capture(c);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_last, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b%b%b_%h want=100_00000000", req_ready, rsp_valid, rsp_last, rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_beat} !== {1'b1, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL post_reset got=%b%b%0d want=1_0_0", req_ready, rsp_valid, rsp_beat);
        end
    endtask

    task automatic test_write;
        run_req(1'b1, 10'h010, 32'hDEADBEEF, 5);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (s_valid[c] !== (c == 3) || s_last[c] !== (c == 3) || s_ready[c] !== (c == 4)
                || s_data[c] !== 32'h0 || s_beat[c] !== 2'd0) begin
                miscompares++;
                $display("FAIL write_ack c=%0d got v=%b l=%b r=%b d=%h b=%0d want v=%b l=%b r=%b d=0 b=0",
                         c, s_valid[c], s_last[c], s_ready[c], s_data[c], s_beat[c], c == 3, c == 3, c == 4);
            end
        end
    endtask

    task automatic test_read_burst;
        for (int i = 0; i < 4; i++) run_req(1'b1, 10'(10'h010 + i), 32'(i + 1), 5);
        run_req(1'b0, 10'h012, 32'h0, 8);
        for (int c = 0; c < 8; c++) begin
            logic        ev;
            logic [31:0] ed;
            logic [1:0]  eb;
            ev = (c >= 3 && c <= 6);
            ed = ev ? 32'(c - 2) : 32'h0;
            eb = ev ? 2'(c - 3) : 2'd0;
            vectors++;
            if (s_valid[c] !== ev || s_data[c] !== ed || s_beat[c] !== eb
                || s_last[c] !== (c == 6) || s_ready[c] !== (c == 7)) begin
                miscompares++;
                $display("FAIL read_burst c=%0d got v=%b d=%h b=%0d l=%b r=%b want v=%b d=%h b=%0d l=%b r=%b",
                         c, s_valid[c], s_data[c], s_beat[c], s_last[c], s_ready[c], ev, ed, eb, c == 6, c == 7);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) run_req(1'b1, 10'(10'h020 + i), 32'(32'h100 + i), 5);
        run_req(1'b0, 10'h021, 32'h0, 0);
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 10'h030;
        req_wdata = 32'h77;
        for (int c = 0; c < 13; c++) begin
            logic ev;
            logic er;
            @(negedge clk);
            capture(c);
            if (c == 8) req_valid = 1'b0;
            ev = (c >= 3 && c <= 6) || (c == 11);
            er = (c == 7) || (c == 12);
            vectors++;
            if (s_valid[c] !== ev || s_ready[c] !== er) begin
                miscompares++;
                $display("FAIL held_req c=%0d got v=%b r=%b want v=%b r=%b", c, s_valid[c], s_ready[c], ev, er);
            end
            if (c >= 3 && c <= 6) begin
                vectors++;
                if (s_data[c] !== 32'(32'h100 + c - 3)) begin
                    miscompares++;
                    $display("FAIL held_req_data c=%0d got=%h want=%h", c, s_data[c], 32'h100 + c - 3);
                end
            end
        end
        run_req(1'b0, 10'h030, 32'h0, 8);
        vectors++;
        if (s_data[3] !== 32'h77) begin
            miscompares++;
            $display("FAIL second_req_write got=%h want=00000077", s_data[3]);
        end
    endtask

    task automatic test_reset_mid;
        run_req(1'b0, 10'h010, 32'h0, 5);
        vectors++;
        if (s_valid[4] !== 1'b1 || s_data[4] !== 32'h2) begin
            miscompares++;
            $display("FAIL pre_abort got v=%b d=%h want v=1 d=00000002", s_valid[4], s_data[4]);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_last !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_async got v=%b r=%b l=%b want v=0 r=1 l=0", rsp_valid, req_ready, rsp_last);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL abort_quiet c=%0d got v=%b r=%b want v=0 r=1", c, rsp_valid, req_ready);
            end
        end
        run_req(1'b0, 10'h013, 32'h0, 8);
        for (int c = 3; c < 7; c++) begin
            vectors++;
            if (s_valid[c] !== 1'b1 || s_data[c] !== 32'(c - 2) || s_last[c] !== (c == 6)) begin
                miscompares++;
                $display("FAIL reread c=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         c, s_valid[c], s_data[c], s_last[c], 32'(c - 2), c == 6);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] exp32;
        run_req(1'b1, 10'd32, 32'h1234, 5);
        run_req(1'b1, 10'd800, 32'h55, 5);
        vectors++;
`ifdef MEM_RESP_ERR_EN
        if (s_valid[3] !== 1'b1 || s_last[3] !== 1'b1 || s_err[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_write_ack got v=%b l=%b e=%b want 1 1 1", s_valid[3], s_last[3], s_err[3]);
        end
        exp32 = 32'h1234;
`else
        if (s_valid[3] !== 1'b1 || s_last[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_write_ack got v=%b l=%b want 1 1", s_valid[3], s_last[3]);
        end
        exp32 = 32'h55;
`endif
        run_req(1'b0, 10'd32, 32'h0, 8);
        vectors++;
        if (s_data[3] !== exp32 || s_err[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_alias got d=%h e=%b want d=%h e=0", s_data[3], s_err[3], exp32);
        end
        run_req(1'b0, 10'd800, 32'h0, 8);
        vectors++;
`ifdef MEM_RESP_ERR_EN
        if (s_data[3] !== 32'h0 || s_err[3] !== 1'b1 || s_err[6] !== 1'b1 || s_err[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_read got d=%h e3=%b e6=%b e7=%b want d=0 e3=1 e6=1 e7=0",
                     s_data[3], s_err[3], s_err[6], s_err[7]);
        end
`else
        if (s_data[3] !== 32'h55) begin
            miscompares++;
            $display("FAIL oor_read got d=%h want d=00000055", s_data[3]);
        end
`endif
        run_req(1'b1, 10'd767, 32'hABC, 5);
        run_req(1'b0, 10'd767, 32'h0, 8);
        vectors++;
        if (s_data[6] !== 32'hABC || s_beat[6] !== 2'd3 || s_last[6] !== 1'b1 || s_err[6] !== 1'b0) begin
            miscompares++;
            $display("FAIL top_word got d=%h b=%0d l=%b e=%b want d=00000abc b=3 l=1 e=0",
                     s_data[6], s_beat[6], s_last[6], s_err[6]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_rw      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        test_reset();
        test_write();
        test_read_burst();
        test_back_to_back();
        test_reset_mid();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
